// File: rtl/regfile_8x16_sb.sv
// regfile_8x16_sb: 8x16 register file with two bypassed read ports, one write-back port and a busy scoreboard
module regfile_8x16_sb #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_dest,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec
);
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_wb_live;
    logic             w_haz_a;
    logic             w_haz_b;
    logic             w_haz_d;
    logic             w_accept;

    assign w_wb_live = wb_en && !reset && wb_addr != '0;
    assign w_haz_a   = r_busy[rd_addr_a] && !(w_wb_live && wb_addr == rd_addr_a);
    assign w_haz_b   = r_busy[rd_addr_b] && !(w_wb_live && wb_addr == rd_addr_b);
    assign w_haz_d   = issue_valid && r_busy[issue_dest] && !(w_wb_live && wb_addr == issue_dest);
    assign stall     = !reset && (w_haz_a || w_haz_b || w_haz_d);
    assign w_accept  = issue_valid && !stall && !reset;
    assign busy_vec  = r_busy;

    // Read ports: R0 is zero, an in-flight write-back is forwarded, else storage
    always_comb begin
        rd_data_a = rd_addr_a == '0 ? '0 : (w_wb_live && wb_addr == rd_addr_a) ? wb_data : r_regs[rd_addr_a];
        rd_data_b = rd_addr_b == '0 ? '0 : (w_wb_live && wb_addr == rd_addr_b) ? wb_data : r_regs[rd_addr_b];
    end

    // Scoreboard next state: a newly accepted producer outranks a completing one
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            w_busy_nxt[i] = (w_accept && issue_dest == AW'(i)) ? 1'b1 :
                            (w_wb_live && wb_addr == AW'(i))   ? 1'b0 : r_busy[i];
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Storage and scoreboard update; reset wipes both and blocks the write
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wb_live) r_regs[wb_addr] <= wb_data;
            r_busy <= w_busy_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_8x16_sb.sv
// tb_regfile_8x16_sb: directed and random checks of regfile_8x16_sb against an array-based model
module tb_regfile_8x16_sb;
    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  rd_addr_a, rd_addr_b, issue_dest, wb_addr;
    logic [15:0] rd_data_a, rd_data_b, wb_data;
    logic        issue_valid, wb_en, stall;
    logic [7:0]  busy_vec;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] m_reg [8];
    bit          m_busy [8];

    regfile_8x16_sb dut (
        .clock(clock), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall(stall), .busy_vec(busy_vec)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit wb_hits(input logic [2:0] a);
        return !reset && wb_en && wb_addr == a && a != 0;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (a == 0) return 16'h0;
        if (wb_hits(a)) return wb_data;
        return m_reg[a];
    endfunction

    function automatic bit m_stall();
        bit h;
        h = (m_busy[rd_addr_a] && !wb_hits(rd_addr_a)) ||
            (m_busy[rd_addr_b] && !wb_hits(rd_addr_b)) ||
            (issue_valid && m_busy[issue_dest] && !wb_hits(issue_dest));
        return !reset && h;
    endfunction

    function automatic logic [7:0] m_busy_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic check_now();
        @(negedge clock);
        chk("rd_a", rd_data_a, m_read(rd_addr_a));
        chk("rd_b", rd_data_b, m_read(rd_addr_b));
        chk("stall", 16'(stall), 16'(m_stall()));
        chk("busy", 16'(busy_vec), 16'(m_busy_vec()));
    endtask

    task automatic tick();
        bit acc;
        @(posedge clock);
        acc = issue_valid && !m_stall();
        if (reset) begin
            for (int i = 0; i < 8; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
        end else begin
            if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
            if (wb_en && wb_addr != 0) m_busy[wb_addr] = 0;
            if (acc && issue_dest != 0) m_busy[issue_dest] = 1;
        end
        #1;
    endtask

    task automatic step();
        check_now();
        tick();
    endtask

    task automatic idle();
        reset = 0; wb_en = 0; issue_valid = 0;
        rd_addr_a = 0; rd_addr_b = 0; issue_dest = 0; wb_addr = 0; wb_data = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        tick();
        check_now();
        tick();
        reset = 0;
        // write then read back; unwritten register reads zero
        wb_en = 1; wb_addr = 3; wb_data = 16'hBEEF; rd_addr_b = 5;
        check_now(); chk("rdb_unwritten", rd_data_b, 16'h0000); tick();
        wb_en = 0; rd_addr_a = 3;
        check_now(); chk("beef", rd_data_a, 16'hBEEF); tick();
        // R0 ignores writes and issue
        idle(); wb_en = 1; wb_data = 16'hFFFF; issue_valid = 1; issue_dest = 0;
        step();
        idle();
        check_now(); chk("r0_a", rd_data_a, 16'h0); chk("r0_b", rd_data_b, 16'h0);
        chk("busy0", 16'(busy_vec[0]), 16'h0); tick();
        // same-cycle bypass
        wb_en = 1; wb_addr = 4; wb_data = 16'h1111; step();
        wb_data = 16'h2222; rd_addr_a = 4;
        check_now(); chk("bypass", rd_data_a, 16'h2222); tick();
        wb_en = 0;
        check_now(); chk("stored", rd_data_a, 16'h2222); tick();
        // RAW hazard resolved by write-back
        idle(); issue_valid = 1; issue_dest = 2; step();
        issue_valid = 0; rd_addr_b = 2;
        check_now(); chk("busy_04", 16'(busy_vec), 16'h0004); chk("raw_stall", 16'(stall), 16'h1); tick();
        wb_en = 1; wb_addr = 2; wb_data = 16'h00AA;
        check_now(); chk("raw_clear", 16'(stall), 16'h0); chk("raw_fwd", rd_data_b, 16'h00AA); tick();
        idle();
        check_now(); chk("busy_00", 16'(busy_vec), 16'h0000); tick();
        // WAW stall, then issue coincident with write-back
        issue_valid = 1; issue_dest = 5; step();
        check_now(); chk("waw_stall", 16'(stall), 16'h1); tick();
        check_now(); chk("waw_busy", 16'(busy_vec), 16'h0020);
        wb_en = 1; wb_addr = 5; wb_data = 16'h1234;
        check_now(); chk("waw_go", 16'(stall), 16'h0); tick();
        idle(); rd_addr_b = 5;
        check_now(); chk("busy5_kept", 16'(busy_vec[5]), 16'h1); tick();
        wb_en = 1; wb_addr = 5; wb_data = 16'h4321; step();
        idle(); rd_addr_a = 5;
        check_now(); chk("reg5", rd_data_a, 16'h4321); tick();
        // reset mid-operation
        idle(); issue_valid = 1; issue_dest = 2; step();
        issue_dest = 3; step();
        idle();
        check_now(); chk("busy_0c", 16'(busy_vec), 16'h000C); tick();
        reset = 1; wb_en = 1; wb_addr = 3; wb_data = 16'h5555; rd_addr_a = 2;
        check_now(); chk("rst_stall", 16'(stall), 16'h0); tick();
        idle(); rd_addr_a = 3; rd_addr_b = 4;
        check_now();
        chk("rst_r3", rd_data_a, 16'h0); chk("rst_r4", rd_data_b, 16'h0);
        chk("rst_busy", 16'(busy_vec), 16'h0); chk("rst_stall2", 16'(stall), 16'h0);
        tick();
        // random traffic
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 59) == 0);
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_dest  = 3'($urandom_range(0, 7));
            wb_en       = ($urandom_range(0, 9) < 4);
            wb_addr     = 3'($urandom_range(0, 7));
            wb_data     = 16'($urandom);
            rd_addr_a   = 3'($urandom_range(0, 7));
            rd_addr_b   = 3'($urandom_range(0, 7));
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
